pdp8_mem_arb: RTL and testbench
===============================

Name: pdp8_mem_arb

Overview:
Two-port arbiter and access sequencer in front of the 32Kx12 main memory / async-SRAM interface block.
- Shares main memory between the CPU and one data-break (DMA) device.
- Converts each granted request into a timed read or write cycle (setup, strobe width, hold) suitable for the async SRAM.
- Returns a single-cycle acknowledge, plus read data for reads.
- Its mem_* outputs drive the RAM block's addr/data_in/rd/wr; the RAM block's data_out returns on mem_rdata.

Parameters:
RD_CYCLES, 2, clocks mem_rd is held asserted per read (>=1)
WR_CYCLES, 2, clocks mem_wr is held asserted per write (>=1)
DMA_BURST, 4, max consecutive DMA grants while cpu_req is pending before the CPU is forced a grant (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_wr  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  15  CPU word address (field+address)
cpu_wdata  in  12  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  12  read data, valid when cpu_ack
dma_req  in  1  data-break request, held until dma_ack
dma_wr  in  1  1=write, 0=read
dma_addr  in  15  DMA word address
dma_wdata  in  12  DMA write data
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  12  read data, valid when dma_ack
mem_addr  out  15  to RAM addr
mem_wdata  out  12  to RAM data_in
mem_rd  out  1  to RAM rd
mem_wr  out  1  to RAM wr
mem_rdata  in  12  from RAM data_out
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs registered.
- Reset values: all outputs 0; state=IDLE; starve counter=0; rdata register=0.
- Requester rules:
  - req, wr, addr and wdata must be held stable from req assertion until the ack cycle.
  - Ack is a one-cycle pulse.
  - The requester may re-assert or keep req on the cycle after ack; this is treated as a new request.
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise select a winner: DMA wins, except that the CPU wins when cpu_req=1 and starve==DMA_BURST.
  - Latch the grant owner, mem_addr and mem_wdata (on writes).
  - Go to READ with mem_rd=1, or to WSETUP.
- READ:
  - Lasts RD_CYCLES clocks with mem_rd=1.
  - On the last READ clock, capture mem_rdata into the rdata register, drop mem_rd, go to ACK.
- WSETUP: 1 clock; address and data driven, mem_wr=0. Then go to WPULSE.
- WPULSE: WR_CYCLES clocks with mem_wr=1. Then go to WHOLD.
- WHOLD: 1 clock with mem_wr=0; mem_addr and mem_wdata held. Then go to ACK.
- ACK:
  - The owner's ack=1 for exactly one clock. The other ack stays 0.
  - cpu_rdata and dma_rdata both present the rdata register; writes do not modify it.
  - Next state is IDLE.
- Latency, counting the IDLE cycle in which req is sampled as cycle 0:
  - Read ack at cycle RD_CYCLES+1 (default 3).
  - Write ack at cycle WR_CYCLES+3 (default 5).
  - Back-to-back throughput: one read per RD_CYCLES+2 clocks.
- mem_addr and mem_wdata hold their last values in IDLE. mem_rd and mem_wr are never both 1.
- Starve counter:
  - Increments, saturating at DMA_BURST, on each DMA grant made while cpu_req=1.
  - Clears on a CPU grant, and in IDLE whenever cpu_req=0.
- Simultaneous requests: with starve<DMA_BURST, DMA is served. The CPU request waits, unacknowledged, with no loss.
- Request dropped mid-access (protocol violation): the access completes and the ack is still issued.
- Reset asserted mid-operation:
  - Immediate return to IDLE, independent of clk.
  - mem_wr and mem_rd drop asynchronously.
  - No ack is issued; the in-flight access is abandoned.

Decomposition:
- Shared package pdp8_mem_pkg:
  - Constants PDP8_ADDR_W=15, PDP8_DATA_W=12.
  - State encoding for IDLE/READ/WSETUP/WPULSE/WHOLD/ACK.
  - Owner encoding OWN_CPU/OWN_DMA.
- One natural sub-module, pdp8_mem_prio: IDLE-cycle winner selection plus the starve counter.
- The sequencer FSM and the wait-state counter stay in pdp8_mem_arb.

Test Plan:
- CPU read, defaults, mem_rdata=12'o1234 → mem_addr=cpu_addr and mem_rd=1 for exactly 2 clocks; cpu_ack on cycle 3 with cpu_rdata=12'o1234; dma_ack stays 0.
- DMA write to 15'o07777 with 12'o5252 → WSETUP 1 clk (mem_wr=0), mem_wr=1 for 2 clks, 1 hold clk; dma_ack on cycle 5; mem_addr/mem_wdata stable throughout.
- cpu_req and dma_req held continuously, all reads, DMA_BURST=4 → grant order D,D,D,D,C,D,D,D,D,C; each ack a single pulse.
- DMA idle and CPU issues 3 back-to-back reads → cpu_ack every 4 clocks; mem_rd never asserted in IDLE cycles.
- Reset pulse in the second WPULSE clock → mem_wr=0 immediately; no ack; state IDLE; a subsequent read completes normally.
- RD_CYCLES=1, WR_CYCLES=3 → read ack at cycle 2, write ack at cycle 6; mem_rd and mem_wr never high together.

Source files
------------

// File: rtl/pdp8_mem_pkg.sv
// Shared definitions for the PDP-8 main-memory arbiter slice.
//   PDP8_ADDR_W / PDP8_DATA_W : 15-bit word address (field+address), 12-bit word
//   state_t                   : access sequencer states
//   owner_t                   : which requester holds the current grant
package pdp8_mem_pkg;

   localparam int PDP8_ADDR_W = 15;
   localparam int PDP8_DATA_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_WSETUP = 3'd2,
      ST_WPULSE = 3'd3,
      ST_WHOLD  = 3'd4,
      ST_ACK    = 3'd5
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

endpackage

// File: rtl/pdp8_mem_prio.sv
// Winner selection for the IDLE cycle plus the CPU starvation counter.
//   clk, reset : clock, asynchronous active-high reset
//   idle       : sequencer is in IDLE this cycle
//   cpu_req    : CPU request
//   dma_req    : data-break request
//   grant      : a grant is made this cycle (combinational)
//   owner      : winner of that grant (combinational)
module pdp8_mem_prio
   import pdp8_mem_pkg::*;
#(
   parameter int DMA_BURST = 4
)(
   input  logic   clk,
   input  logic   reset,
   input  logic   idle,
   input  logic   cpu_req,
   input  logic   dma_req,
   output logic   grant,
   output owner_t owner
);

   localparam logic [7:0] BURST_MAX = 8'(DMA_BURST);

   logic [7:0] starve;

   // DMA normally wins; the CPU is forced through once DMA has had BURST_MAX grants in a row.
   always_comb begin
      grant = 1'b0;
      owner = OWN_DMA;
      if (idle && (cpu_req || dma_req)) begin
         grant = 1'b1;
         if (cpu_req && (!dma_req || (starve == BURST_MAX))) begin
            owner = OWN_CPU;
         end else begin
            owner = OWN_DMA;
         end
      end else begin
         grant = 1'b0;
         owner = OWN_DMA;
      end
   end

   // Starve counter: counts DMA grants that bypassed a waiting CPU, saturating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve <= 8'd0;
      end else if (idle && !cpu_req) begin
         starve <= 8'd0;
      end else if (grant && (owner == OWN_CPU)) begin
         starve <= 8'd0;
      end else if (grant && (starve != BURST_MAX)) begin
         starve <= starve + 8'd1;
      end else begin
         starve <= starve;
      end
   end

endmodule

// File: rtl/pdp8_mem_arb.sv
// Two-port (CPU / data-break) arbiter and async-SRAM access sequencer.
//   clk, reset                          : clock, asynchronous active-high reset
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata   : CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata                   : one-cycle completion pulse, read data
//   dma_req/dma_wr/dma_addr/dma_wdata   : data-break request, held until dma_ack
//   dma_ack/dma_rdata                   : one-cycle completion pulse, read data
//   mem_addr/mem_wdata/mem_rd/mem_wr    : drive the RAM block
//   mem_rdata                           : RAM read data
//   busy                                : high in every state except IDLE
// Every output comes straight from a flop; next values are computed from next_state.
module pdp8_mem_arb
   import pdp8_mem_pkg::*;
#(
   parameter int RD_CYCLES = 2,
   parameter int WR_CYCLES = 2,
   parameter int DMA_BURST = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_req,
   input  logic                   cpu_wr,
   input  logic [PDP8_ADDR_W-1:0] cpu_addr,
   input  logic [PDP8_DATA_W-1:0] cpu_wdata,
   output logic                   cpu_ack,
   output logic [PDP8_DATA_W-1:0] cpu_rdata,
   input  logic                   dma_req,
   input  logic                   dma_wr,
   input  logic [PDP8_ADDR_W-1:0] dma_addr,
   input  logic [PDP8_DATA_W-1:0] dma_wdata,
   output logic                   dma_ack,
   output logic [PDP8_DATA_W-1:0] dma_rdata,
   output logic [PDP8_ADDR_W-1:0] mem_addr,
   output logic [PDP8_DATA_W-1:0] mem_wdata,
   output logic                   mem_rd,
   output logic                   mem_wr,
   input  logic [PDP8_DATA_W-1:0] mem_rdata,
   output logic                   busy
);

   localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
   localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

   state_t                 state;
   state_t                 next_state;
   owner_t                 owner;
   owner_t                 win;
   logic                   grant;
   logic                   idle;
   logic [7:0]             wait_cnt;
   logic [PDP8_DATA_W-1:0] rdata;
   logic                   sel_wr;
   logic [PDP8_ADDR_W-1:0] sel_addr;
   logic [PDP8_DATA_W-1:0] sel_wdata;
   logic                   nxt_mem_rd;
   logic                   nxt_mem_wr;
   logic                   nxt_busy;
   logic                   nxt_cpu_ack;
   logic                   nxt_dma_ack;

   assign idle      = (state == ST_IDLE);
   assign cpu_rdata = rdata;
   assign dma_rdata = rdata;

   pdp8_mem_prio #(
      .DMA_BURST (DMA_BURST)
   ) u_prio (
      .clk     (clk),
      .reset   (reset),
      .idle    (idle),
      .cpu_req (cpu_req),
      .dma_req (dma_req),
      .grant   (grant),
      .owner   (win)
   );

   // Steer the winning requester's command onto the internal request bus.
   always_comb begin
      if (win == OWN_CPU) begin
         sel_wr    = cpu_wr;
         sel_addr  = cpu_addr;
         sel_wdata = cpu_wdata;
      end else begin
         sel_wr    = dma_wr;
         sel_addr  = dma_addr;
         sel_wdata = dma_wdata;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic for the access sequencer.
   always_comb begin
      next_state = ST_IDLE;
      case (state)
         ST_IDLE: begin
            if (grant) begin
               next_state = sel_wr ? ST_WSETUP : ST_READ;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_READ:   next_state = (wait_cnt == RD_LAST) ? ST_ACK : ST_READ;
         ST_WSETUP: next_state = ST_WPULSE;
         ST_WPULSE: next_state = (wait_cnt == WR_LAST) ? ST_WHOLD : ST_WPULSE;
         ST_WHOLD:  next_state = ST_ACK;
         ST_ACK:    next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Output decode: values the output flops take on entering next_state.
   always_comb begin
      nxt_mem_rd  = (next_state == ST_READ);
      nxt_mem_wr  = (next_state == ST_WPULSE);
      nxt_busy    = (next_state != ST_IDLE);
      nxt_cpu_ack = (next_state == ST_ACK) && (owner == OWN_CPU);
      nxt_dma_ack = (next_state == ST_ACK) && (owner == OWN_DMA);
   end

   // Wait-state counter: clocks spent so far in the current READ or WPULSE stretch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 8'd0;
      end else if (((state == ST_READ) || (state == ST_WPULSE)) && (next_state == state)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= 8'd0;
      end
   end

   // Grant latch, address/data hold and read-data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner     <= OWN_CPU;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         if (grant) begin
            owner    <= win;
            mem_addr <= sel_addr;
            if (sel_wr) begin
               mem_wdata <= sel_wdata;
            end
         end
         if ((state == ST_READ) && (wait_cnt == RD_LAST)) begin
            rdata <= mem_rdata;
         end
      end
   end

   // Output flops for strobes, acks and busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rd  <= 1'b0;
         mem_wr  <= 1'b0;
         busy    <= 1'b0;
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
      end else begin
         mem_rd  <= nxt_mem_rd;
         mem_wr  <= nxt_mem_wr;
         busy    <= nxt_busy;
         cpu_ack <= nxt_cpu_ack;
         dma_ack <= nxt_dma_ack;
      end
   end

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Directed self-checking bench for pdp8_mem_arb.
// u0 uses default parameters; u1 (RD_CYCLES=1, WR_CYCLES=3) shares the same
// stimulus and is only checked in test_short_params, after a reset re-aligns it.
module tb_pdp8_mem_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_wr, dma_req, dma_wr;
   logic [14:0] cpu_addr, dma_addr;
   logic [11:0] cpu_wdata, dma_wdata, mem_rdata;

   logic        u0_cpu_ack, u0_dma_ack, u0_mem_rd, u0_mem_wr, u0_busy;
   logic [11:0] u0_cpu_rdata, u0_dma_rdata, u0_mem_wdata;
   logic [14:0] u0_mem_addr;
   logic        u1_cpu_ack, u1_dma_ack, u1_mem_rd, u1_mem_wr, u1_busy;
   logic [11:0] u1_cpu_rdata, u1_dma_rdata, u1_mem_wdata;
   logic [14:0] u1_mem_addr;

   int checks   = 0;
   int failures = 0;
   int overlap  = 0;

   always #5 clk = ~clk;

   pdp8_mem_arb u0 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(u0_cpu_ack), .cpu_rdata(u0_cpu_rdata),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(u0_dma_ack), .dma_rdata(u0_dma_rdata),
      .mem_addr(u0_mem_addr), .mem_wdata(u0_mem_wdata), .mem_rd(u0_mem_rd), .mem_wr(u0_mem_wr),
      .mem_rdata(mem_rdata), .busy(u0_busy)
   );

   pdp8_mem_arb #(.RD_CYCLES(1), .WR_CYCLES(3), .DMA_BURST(4)) u1 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(u1_cpu_ack), .cpu_rdata(u1_cpu_rdata),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(u1_dma_ack), .dma_rdata(u1_dma_rdata),
      .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_rd(u1_mem_rd), .mem_wr(u1_mem_wr),
      .mem_rdata(mem_rdata), .busy(u1_busy)
   );

   // Strobe exclusivity monitor for both instances.
   always @(negedge clk) begin
      if ((u0_mem_rd && u0_mem_wr) || (u1_mem_rd && u1_mem_wr)) overlap++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      checks++;
      if ({u0_cpu_ack, u0_dma_ack, u0_mem_rd, u0_mem_wr, u0_busy} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_ctl: got %b expected 00000",
                  {u0_cpu_ack, u0_dma_ack, u0_mem_rd, u0_mem_wr, u0_busy});
      end
      checks++;
      if (u0_mem_addr !== 15'o00000) begin
         failures++; $display("FAIL reset_mem_addr: got %o expected 0", u0_mem_addr);
      end
      checks++;
      if (u0_mem_wdata !== 12'o0000) begin
         failures++; $display("FAIL reset_mem_wdata: got %o expected 0", u0_mem_wdata);
      end
      checks++;
      if ({u0_cpu_rdata, u0_dma_rdata} !== 24'd0) begin
         failures++; $display("FAIL reset_rdata: got %o/%o expected 0/0", u0_cpu_rdata, u0_dma_rdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick;
      checks++;
      if (u0_busy !== 1'b0) begin
         failures++; $display("FAIL reset_idle_busy: got %b expected 0", u0_busy);
      end
   endtask

   task automatic test_cpu_read;
      cpu_wr = 1'b0; cpu_addr = 15'o12345; mem_rdata = 12'o1234; cpu_req = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick;
         checks++;
         if (u0_mem_rd !== (c <= 2)) begin
            failures++; $display("FAIL cpu_read_mem_rd cycle %0d: got %b expected %b", c, u0_mem_rd, (c <= 2));
         end
         checks++;
         if (u0_cpu_ack !== (c == 3)) begin
            failures++; $display("FAIL cpu_read_ack cycle %0d: got %b expected %b", c, u0_cpu_ack, (c == 3));
         end
         checks++;
         if (u0_dma_ack !== 1'b0) begin
            failures++; $display("FAIL cpu_read_dma_ack cycle %0d: got %b expected 0", c, u0_dma_ack);
         end
         if (c <= 2) begin
            checks++;
            if (u0_mem_addr !== 15'o12345) begin
               failures++; $display("FAIL cpu_read_addr cycle %0d: got %o expected 12345", c, u0_mem_addr);
            end
         end else begin
            checks++;
            if (u0_cpu_rdata !== 12'o1234 || u0_dma_rdata !== 12'o1234) begin
               failures++; $display("FAIL cpu_read_rdata: got %o/%o expected 1234/1234", u0_cpu_rdata, u0_dma_rdata);
            end
            cpu_req = 1'b0;
         end
      end
      tick;
      checks++;
      if (u0_busy !== 1'b0) begin
         failures++; $display("FAIL cpu_read_idle: got busy %b expected 0", u0_busy);
      end
   endtask

   task automatic test_dma_write;
      dma_wr = 1'b1; dma_addr = 15'o07777; dma_wdata = 12'o5252; dma_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick;
         checks++;
         if (u0_mem_wr !== (c == 2 || c == 3) || u0_mem_rd !== 1'b0) begin
            failures++; $display("FAIL dma_write_strobe cycle %0d: got wr=%b rd=%b expected wr=%b rd=0",
                                 c, u0_mem_wr, u0_mem_rd, (c == 2 || c == 3));
         end
         checks++;
         if (u0_mem_addr !== 15'o07777 || u0_mem_wdata !== 12'o5252) begin
            failures++; $display("FAIL dma_write_bus cycle %0d: got %o/%o expected 07777/5252", c, u0_mem_addr, u0_mem_wdata);
         end
         checks++;
         if (u0_dma_ack !== (c == 5) || u0_cpu_ack !== 1'b0) begin
            failures++; $display("FAIL dma_write_ack cycle %0d: got dma=%b cpu=%b expected dma=%b cpu=0",
                                 c, u0_dma_ack, u0_cpu_ack, (c == 5));
         end
         if (c == 5) dma_req = 1'b0;
      end
      checks++;
      if (u0_dma_rdata !== 12'o1234) begin
         failures++; $display("FAIL dma_write_rdata_kept: got %o expected 1234", u0_dma_rdata);
      end
      tick;
   endtask

   task automatic test_arbitration;
      logic [9:0] order;
      logic       exp_cpu;
      order  = 10'b1000010000;   // bit g set = grant g goes to the CPU
      cpu_wr = 1'b0; dma_wr = 1'b0;
      cpu_addr = 15'o00100; dma_addr = 15'o00200;
      cpu_req = 1'b1; dma_req = 1'b1;
      for (int g = 0; g < 10; g++) begin
         exp_cpu = order[g];
         tick;
         checks++;
         if (u0_mem_addr !== (exp_cpu ? 15'o00100 : 15'o00200)) begin
            failures++; $display("FAIL arb_grant %0d: got addr %o expected %o", g, u0_mem_addr,
                                 (exp_cpu ? 15'o00100 : 15'o00200));
         end
         tick;
         tick;
         checks++;
         if (u0_cpu_ack !== exp_cpu || u0_dma_ack !== !exp_cpu) begin
            failures++; $display("FAIL arb_ack %0d: got cpu=%b dma=%b expected cpu=%b dma=%b",
                                 g, u0_cpu_ack, u0_dma_ack, exp_cpu, !exp_cpu);
         end
         tick;
         checks++;
         if (u0_cpu_ack !== 1'b0 || u0_dma_ack !== 1'b0) begin
            failures++; $display("FAIL arb_ack_pulse %0d: got cpu=%b dma=%b expected 0/0", g, u0_cpu_ack, u0_dma_ack);
         end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      tick;
   endtask

   task automatic test_back_to_back;
      logic [11:0] vals [3];
      logic [14:0] addrs [3];
      vals[0] = 12'o0011; vals[1] = 12'o2222; vals[2] = 12'o7654;
      addrs[0] = 15'o10000; addrs[1] = 15'o10001; addrs[2] = 15'o77777;
      dma_req = 1'b0; cpu_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cpu_addr = addrs[k]; mem_rdata = vals[k]; cpu_req = 1'b1;
         for (int c = 1; c <= 4; c++) begin
            tick;
            checks++;
            if (u0_cpu_ack !== (c == 3)) begin
               failures++; $display("FAIL b2b_ack read %0d cycle %0d: got %b expected %b", k, c, u0_cpu_ack, (c == 3));
            end
            if (c <= 2) begin
               checks++;
               if (u0_mem_rd !== 1'b1 || u0_mem_addr !== addrs[k]) begin
                  failures++; $display("FAIL b2b_read %0d cycle %0d: got rd=%b addr=%o expected rd=1 addr=%o",
                                       k, c, u0_mem_rd, u0_mem_addr, addrs[k]);
               end
            end else if (c == 3) begin
               checks++;
               if (u0_cpu_rdata !== vals[k]) begin
                  failures++; $display("FAIL b2b_rdata %0d: got %o expected %o", k, u0_cpu_rdata, vals[k]);
               end
               if (k == 2) cpu_req = 1'b0;
            end else begin
               checks++;
               if (u0_busy !== 1'b0 || u0_mem_rd !== 1'b0) begin
                  failures++; $display("FAIL b2b_idle %0d: got busy=%b rd=%b expected 0/0", k, u0_busy, u0_mem_rd);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_write;
      cpu_wr = 1'b1; cpu_addr = 15'o00300; cpu_wdata = 12'o7070; cpu_req = 1'b1;
      tick;
      checks++;
      if (u0_mem_wr !== 1'b0 || u0_mem_wdata !== 12'o7070) begin
         failures++; $display("FAIL rst_wsetup: got wr=%b wdata=%o expected 0/7070", u0_mem_wr, u0_mem_wdata);
      end
      tick;
      tick;
      checks++;
      if (u0_mem_wr !== 1'b1) begin
         failures++; $display("FAIL rst_wpulse2: got wr=%b expected 1", u0_mem_wr);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (u0_mem_wr !== 1'b0 || u0_mem_rd !== 1'b0 || u0_busy !== 1'b0) begin
         failures++; $display("FAIL rst_async: got wr=%b rd=%b busy=%b expected 0/0/0", u0_mem_wr, u0_mem_rd, u0_busy);
      end
      cpu_req = 1'b0; cpu_wr = 1'b0;
      #1 reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick;
         checks++;
         if (u0_cpu_ack !== 1'b0 || u0_busy !== 1'b0) begin
            failures++; $display("FAIL rst_no_ack cycle %0d: got ack=%b busy=%b expected 0/0", c, u0_cpu_ack, u0_busy);
         end
      end
      checks++;
      if (u0_cpu_rdata !== 12'o0000) begin
         failures++; $display("FAIL rst_rdata_clear: got %o expected 0", u0_cpu_rdata);
      end
      cpu_addr = 15'o00400; mem_rdata = 12'o4321; cpu_req = 1'b1;
      tick;
      checks++;
      if (u0_mem_rd !== 1'b1 || u0_mem_addr !== 15'o00400) begin
         failures++; $display("FAIL rst_after_read_start: got rd=%b addr=%o expected 1/00400", u0_mem_rd, u0_mem_addr);
      end
      tick;
      tick;
      checks++;
      if (u0_cpu_ack !== 1'b1 || u0_cpu_rdata !== 12'o4321) begin
         failures++; $display("FAIL rst_after_read_ack: got ack=%b rdata=%o expected 1/4321", u0_cpu_ack, u0_cpu_rdata);
      end
      cpu_req = 1'b0;
      tick;
   endtask

   task automatic test_short_params;
      reset = 1'b1;
      #2 reset = 1'b0;
      cpu_wr = 1'b0; cpu_addr = 15'o01000; mem_rdata = 12'o0707; cpu_req = 1'b1;
      tick;
      checks++;
      if (u1_mem_rd !== 1'b1 || u1_cpu_ack !== 1'b0 || u1_mem_addr !== 15'o01000) begin
         failures++; $display("FAIL short_read_c1: got rd=%b ack=%b addr=%o expected 1/0/01000",
                              u1_mem_rd, u1_cpu_ack, u1_mem_addr);
      end
      tick;
      checks++;
      if (u1_cpu_ack !== 1'b1 || u1_mem_rd !== 1'b0 || u1_cpu_rdata !== 12'o0707) begin
         failures++; $display("FAIL short_read_ack: got ack=%b rd=%b rdata=%o expected 1/0/0707",
                              u1_cpu_ack, u1_mem_rd, u1_cpu_rdata);
      end
      cpu_req = 1'b0;   // u0 is still mid-read: dropped request must still be acked
      tick;
      checks++;
      if (u0_cpu_ack !== 1'b1) begin
         failures++; $display("FAIL dropped_req_ack: got %b expected 1", u0_cpu_ack);
      end
      dma_wr = 1'b1; dma_addr = 15'o02000; dma_wdata = 12'o1111; dma_req = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick;
         checks++;
         if (u1_mem_wr !== (c >= 2 && c <= 4)) begin
            failures++; $display("FAIL short_write_wr cycle %0d: got %b expected %b", c, u1_mem_wr, (c >= 2 && c <= 4));
         end
         checks++;
         if (u1_dma_ack !== (c == 6)) begin
            failures++; $display("FAIL short_write_ack cycle %0d: got %b expected %b", c, u1_dma_ack, (c == 6));
         end
         if (c == 6) begin
            checks++;
            if (u1_mem_wdata !== 12'o1111 || u1_dma_rdata !== 12'o0707) begin
               failures++; $display("FAIL short_write_data: got wdata=%o rdata=%o expected 1111/0707",
                                    u1_mem_wdata, u1_dma_rdata);
            end
            dma_req = 1'b0;
         end
      end
      repeat (6) tick;
      checks++;
      if (u1_busy !== 1'b0 || u0_busy !== 1'b0) begin
         failures++; $display("FAIL short_final_idle: got busy %b/%b expected 0/0", u0_busy, u1_busy);
      end
      checks++;
      if (overlap !== 0) begin
         failures++; $display("FAIL rd_wr_exclusive: got %0d overlapping cycles expected 0", overlap);
      end
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 15'o00000; cpu_wdata = 12'o0000;
      dma_req = 1'b0; dma_wr = 1'b0; dma_addr = 15'o00000; dma_wdata = 12'o0000;
      mem_rdata = 12'o0000;
      test_reset;
      test_cpu_read;
      test_dma_write;
      test_arbitration;
      test_back_to_back;
      test_reset_mid_write;
      test_short_params;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
